alpha_unit_param: RTL and testbench

- Parametrised forward-metric (alpha) recursion for the max-log-MAP SISO decoder on the 8-state LTE constituent trellis (feedback 1+D^2+D^3, feedforward 1+D+D^3).
- Sits between init_branch and beta_llr.
- Generalises the fixed 16-bit alpha stage: metric width is configurable; per-step normalisation and saturation are added; frames are delimited by blklen with automatic re-initialisation; first/last markers and a blklen error flag are produced.

---
 rtl/alpha_unit_param.sv | 196 +++++++++++++++++++
 tb/tb_alpha_unit_param.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alpha_unit_param.sv
// ---------------------------------------------------------------------------
// alpha_unit_param
//
// Forward-metric (alpha) recursion for a max-log-MAP SISO decoder on the
// 8-state LTE constituent trellis (feedback 1+D^2+D^3, feedforward 1+D+D^3).
// It consumes one trellis step per valid_in. One cycle later it presents the
// metric vector that was in force *before* that step, which is the pairing
// the downstream beta/LLR stage needs. Metrics are normalised to state 0 and
// saturated after every step. Frames are delimited by a latched blklen, and
// the metric register re-initialises itself automatically between frames.
//
// Handshake: valid-only, with no backpressure. valid_blklen qualifies blklen
// and valid_in qualifies lu/lp for exactly the cycle in which they are high.
// valid_out qualifies alpha_flat/first_out/last_out for exactly one cycle.
// The block can never stall, so the producer may issue a step every cycle
// or leave gaps.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   blklen         trellis steps per frame (tail steps included)
//   valid_blklen   qualifies blklen
//   valid_in       qualifies lu/lp (one trellis step)
//   lu, lp         signed systematic+apriori LLR and parity LLR
//   valid_out      alpha_flat valid
//   alpha_flat     alpha_k(s) in bits [W*s+W-1 : W*s], s = 0..7
//   first_out      with valid_out: step k = 0
//   last_out       with valid_out: step k = blklen-1
//   busy           frame in progress
//   err_blklen     sticky: valid_in seen before any blklen was loaded
//
// The FSM state is held in state_q (state_t) so that checkers can bind to it.
// ---------------------------------------------------------------------------
module alpha_unit_param #(
  parameter int W        = 16,
  parameter int NEG_INIT = -(2 ** (W - 2))
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         blklen,
  input  logic                valid_blklen,
  input  logic                valid_in,
  input  logic signed [W-1:0] lu,
  input  logic signed [W-1:0] lp,
  output logic                valid_out,
  output logic [8*W-1:0]      alpha_flat,
  output logic                first_out,
  output logic                last_out,
  output logic                busy,
  output logic                err_blklen
);

  // The add-compare stage runs in W+2 bits: a metric plus two LLRs cannot
  // overflow that width. The difference to state 0 gets one extra bit, so
  // the subtraction is exact and the saturation that follows is exact too.
  localparam int WX = W + 2;
  localparam int WD = W + 3;

  localparam logic signed [W-1:0]  INIT_NEG = W'(NEG_INIT);
  localparam logic signed [WD-1:0] SAT_HI   = WD'((2 ** (W - 1)) - 1);
  localparam logic signed [WD-1:0] SAT_LO   = -SAT_HI;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t              state_q;
  logic [15:0]         blk_q;
  logic [15:0]         cnt_q;
  logic signed [W-1:0] metric_q [8];

  // Trellis, with state s = {s1, s2, s3} and s1 the newest bit.
  // Input u gives a = u^s2^s3, p = a^s1^s3 and next state {a, s1, s2}.
  // Working backwards from a destination d = {a, s1, s2}, the two
  // predecessors differ only in s3. The input bit and parity bit of each
  // branch follow from d and s3 alone.
  function automatic logic [2:0] pred_state(input logic [2:0] d, input logic s3);
    return {d[1], d[0], s3};
  endfunction

  function automatic logic signed [WX-1:0] branch_metric(
    input logic [2:0]         d,
    input logic               s3,
    input logic signed [W-1:0] lu_v,
    input logic signed [W-1:0] lp_v
  );
    logic                 u;
    logic                 p;
    logic signed [WX-1:0] g;
    u = d[2] ^ d[0] ^ s3;   // a ^ s2 ^ s3
    p = d[2] ^ d[1] ^ s3;   // a ^ s1 ^ s3
    g = '0;
    if (u) g = g + WX'(lu_v);
    if (p) g = g + WX'(lp_v);
    return g;
  endfunction

  // Add-compare-select, followed by normalisation to state 0 and saturation.
  logic signed [WX-1:0] best [8];
  logic signed [W-1:0]  norm [8];
  logic signed [WX-1:0] cand0;
  logic signed [WX-1:0] cand1;
  logic signed [WD-1:0] diff;

  always_comb begin
    cand0 = '0;
    cand1 = '0;
    diff  = '0;
    for (int d = 0; d < 8; d++) begin
      cand0 = WX'(metric_q[pred_state(3'(d), 1'b0)]) + branch_metric(3'(d), 1'b0, lu, lp);
      cand1 = WX'(metric_q[pred_state(3'(d), 1'b1)]) + branch_metric(3'(d), 1'b1, lu, lp);
      best[d] = (cand1 > cand0) ? cand1 : cand0;
    end
    for (int d = 0; d < 8; d++) begin
      diff = WD'(best[d]) - WD'(best[0]);
      if (diff > SAT_HI)      norm[d] = W'(SAT_HI);
      else if (diff < SAT_LO) norm[d] = W'(SAT_LO);
      else                    norm[d] = W'(diff);
    end
  end

  logic [8*W-1:0] metric_flat;

  always_comb begin
    metric_flat = '0;
    for (int s = 0; s < 8; s++) begin
      metric_flat[W*s +: W] = metric_q[s];
    end
  end

  // Frame control. A blklen that arrives together with the first step of a
  // frame already governs that frame. That is why the length used for the
  // last-step decision in LOADED is taken from the bus when it is valid.
  logic        blk_new_ok;
  logic [15:0] blk_eff;
  logic        accept;
  logic        step_last;

  always_comb begin
    blk_new_ok = valid_blklen && (blklen != 16'd0);
    blk_eff    = (state_q == LOADED && blk_new_ok) ? blklen : blk_q;
    accept     = valid_in && (state_q != IDLE);
    step_last  = (state_q == LOADED) ? (blk_eff == 16'd1)
                                     : (cnt_q == blk_q - 16'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      blk_q       <= '0;
      cnt_q       <= '0;
      metric_q[0] <= '0;
      for (int s = 1; s < 8; s++) metric_q[s] <= INIT_NEG;
      valid_out   <= 1'b0;
      alpha_flat  <= '0;
      first_out   <= 1'b0;
      last_out    <= 1'b0;
      busy        <= 1'b0;
      err_blklen  <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      first_out <= 1'b0;
      last_out  <= 1'b0;

      // A new length is ignored while a frame is running.
      if (blk_new_ok && state_q != RUN) blk_q <= blklen;

      if (state_q == IDLE) begin
        if (valid_in)   err_blklen <= 1'b1;   // step dropped
        if (blk_new_ok) state_q    <= LOADED;
      end

      if (accept) begin
        valid_out  <= 1'b1;
        alpha_flat <= metric_flat;            // alpha_k, before step k applies
        first_out  <= (state_q == LOADED);
        last_out   <= step_last;
        if (step_last) begin
          // Re-arm for a back-to-back frame with the same length.
          state_q     <= LOADED;
          cnt_q       <= '0;
          busy        <= 1'b0;
          metric_q[0] <= '0;
          for (int s = 1; s < 8; s++) metric_q[s] <= INIT_NEG;
        end else begin
          state_q  <= RUN;
          cnt_q    <= cnt_q + 16'd1;
          busy     <= 1'b1;
          metric_q <= norm;
        end
      end
    end
  end

endmodule

// File: tb/tb_alpha_unit_param.sv
// ---------------------------------------------------------------------------
// tb_alpha_unit_param
//
// Directed bench for alpha_unit_param (W = 16).
// The driver issues steps and pushes the expected output for each accepted
// step into exp_q. A behavioural trellis model, written in the forward
// (source-state) direction, produces those expected outputs. A monitor pops
// exp_q on every valid_out and records what it saw in cap_q. Hand-computed
// values from the test plan are then compared against the recorded outputs.
// ---------------------------------------------------------------------------
module tb_alpha_unit_param;

  localparam int W   = 16;
  localparam int EW  = 8 * W + 2;            // {alpha_flat, first, last}
  localparam int SAT = (2 ** (W - 1)) - 1;

  // ---------------- clock / reset ----------------
  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [15:0]         blklen = '0;
  logic                valid_blklen = 1'b0;
  logic                valid_in = 1'b0;
  logic signed [W-1:0] lu = '0;
  logic signed [W-1:0] lp = '0;
  logic                valid_out;
  logic [8*W-1:0]      alpha_flat;
  logic                first_out;
  logic                last_out;
  logic                busy;
  logic                err_blklen;

  always #5 clk = ~clk;

  alpha_unit_param #(.W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .blklen       (blklen),
    .valid_blklen (valid_blklen),
    .valid_in     (valid_in),
    .lu           (lu),
    .lp           (lp),
    .valid_out    (valid_out),
    .alpha_flat   (alpha_flat),
    .first_out    (first_out),
    .last_out     (last_out),
    .busy         (busy),
    .err_blklen   (err_blklen)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] cap_q[$];

  // ---------------- checks ----------------
  task automatic check_val(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [8*W-1:0] act,
                           input logic [8*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic signed [W-1:0] fld(input logic [EW-1:0] e, input int s);
    return e[2 + W*s +: W];
  endfunction

  function automatic logic [8*W-1:0] vec_of(input logic [EW-1:0] e);
    return e[EW-1:2];
  endfunction

  // Hand vectors: the frame-start vector, and the vector after one all-zero step
  // (only states 0 and 4 are reachable from state 0, both with metric 0).
  function automatic logic [8*W-1:0] hand_init();
    logic [8*W-1:0] v;
    for (int s = 0; s < 8; s++) v[W*s +: W] = (s == 0) ? 16'sd0 : -16'sd16384;
    return v;
  endfunction

  function automatic logic [8*W-1:0] hand_zero_step();
    logic [8*W-1:0] v;
    for (int s = 0; s < 8; s++) v[W*s +: W] = (s == 0 || s == 4) ? 16'sd0 : -16'sd16384;
    return v;
  endfunction

  // ---------------- reference model ----------------
  int m_alpha[8];
  int m_blk    = 0;
  int m_cnt    = 0;
  bit m_loaded = 0;

  function automatic void model_init();
    m_alpha[0] = 0;
    for (int s = 1; s < 8; s++) m_alpha[s] = -16384;
  endfunction

  function automatic void model_step(input int lu_v, input int lp_v);
    int nxt[8];
    bit seen[8];
    int s1, s2, s3, a, p, ns, c, d;
    for (int i = 0; i < 8; i++) begin nxt[i] = 0; seen[i] = 0; end
    for (int s = 0; s < 8; s++) begin
      for (int u = 0; u < 2; u++) begin
        s1 = (s >> 2) & 1;
        s2 = (s >> 1) & 1;
        s3 = s & 1;
        a  = u ^ s2 ^ s3;
        p  = a ^ s1 ^ s3;
        ns = 4 * a + 2 * s1 + s2;
        c  = m_alpha[s] + (u != 0 ? lu_v : 0) + (p != 0 ? lp_v : 0);
        if (!seen[ns] || c > nxt[ns]) begin
          nxt[ns]  = c;
          seen[ns] = 1;
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      d = nxt[i] - nxt[0];
      if (d > SAT)  d = SAT;
      if (d < -SAT) d = -SAT;
      m_alpha[i] = d;
    end
  endfunction

  function automatic logic [8*W-1:0] model_vec();
    logic [8*W-1:0] v;
    for (int s = 0; s < 8; s++) v[W*s +: W] = W'(m_alpha[s]);
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit vb, input int blk, input bit vi,
                       input int lu_v, input int lp_v);
    @(negedge clk);
    valid_blklen = vb;
    blklen       = 16'(blk);
    valid_in     = vi;
    lu           = W'(lu_v);
    lp           = W'(lp_v);
    if (vb && blk != 0 && m_cnt == 0) begin
      m_blk    = blk;
      m_loaded = 1;
    end
    if (vi && m_loaded) begin
      exp_q.push_back({model_vec(), m_cnt == 0, m_cnt == m_blk - 1});
      if (m_cnt == m_blk - 1) begin
        m_cnt = 0;
        model_init();
      end else begin
        m_cnt++;
        model_step(lu_v, lp_v);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst          = 1'b1;
    valid_blklen = 1'b0;
    valid_in     = 1'b0;
    m_loaded     = 0;
    m_cnt        = 0;
    m_blk        = 0;
    model_init();
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- scoreboard / monitor ----------------
  initial begin
    logic [EW-1:0]       e;
    logic signed [W-1:0] m;
    int                  nviol;
    forever begin
      @(negedge clk);
      if (valid_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_valid_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_vec("alpha_flat", alpha_flat, vec_of(e));
          check_val("first_out", first_out, e[1]);
          check_val("last_out", last_out, e[0]);
        end
        nviol = 0;
        for (int s = 0; s < 8; s++) begin
          m = alpha_flat[W*s +: W];
          if (m > SAT || m < -SAT) nviol++;
        end
        check_val("alpha0_zero", $signed(alpha_flat[W-1:0]), 0);
        check_val("alpha_range_violations", nviol, 0);
        cap_q.push_back({alpha_flat, first_out, last_out});
      end
    end
  end

  // ---------------- stimulus ----------------
  int lu_t[6] = '{5, -3, 8, 12, -7, 2};
  int lp_t[6] = '{1, 4, -6, 0, 9, -2};

  initial begin
    model_init();

    // Reset: every output is zero.
    do_reset(2);
    check_val("rst_valid_out", valid_out, 0);
    check_vec("rst_alpha_flat", alpha_flat, '0);
    check_val("rst_first_out", first_out, 0);
    check_val("rst_last_out", last_out, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_err_blklen", err_blklen, 0);

    // Init frame: blklen = 4, all-zero LLRs.
    cap_q.delete();
    cycle(1, 4, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    check_val("init_busy_mid", busy, 1);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    idle(1);
    check_val("init_busy_after", busy, 0);
    idle(2);
    check_val("init_count", cap_q.size(), 4);
    check_vec("init_k0", vec_of(cap_q[0]), hand_init());
    check_val("init_k0_first", cap_q[0][1], 1);
    check_vec("init_k1", vec_of(cap_q[1]), hand_zero_step());
    check_val("init_k3_last", cap_q[3][0], 1);
    check_val("init_k2_last", cap_q[2][0], 0);

    // Branch metrics: blklen = 2, lu only and then lp only.
    cap_q.delete();
    cycle(1, 2, 0, 0, 0);
    cycle(0, 0, 1, 10, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 7);
    cycle(0, 0, 1, 0, 0);
    idle(2);
    check_val("branch_count", cap_q.size(), 4);
    check_val("branch_lu_a0", fld(cap_q[1], 0), 0);
    check_val("branch_lu_a4", fld(cap_q[1], 4), 10);
    check_vec("branch_frame2_init", vec_of(cap_q[2]), hand_init());
    check_val("branch_lp_a4", fld(cap_q[3], 4), 7);
    check_val("branch_lp_last", cap_q[3][0], 1);

    // Saturation: blklen = 40, maximum positive LLRs on every step.
    cap_q.delete();
    cycle(1, 40, 0, 0, 0);
    repeat (40) cycle(0, 0, 1, 32767, 32767);
    idle(2);
    check_val("sat_count", cap_q.size(), 40);
    check_val("sat_last", cap_q[39][0], 1);

    // Back-to-back frames: blklen = 3, six consecutive steps.
    cap_q.delete();
    cycle(1, 3, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, lu_t[i], lp_t[i]);
    idle(2);
    check_val("b2b_count", cap_q.size(), 6);
    check_val("b2b_first0", cap_q[0][1], 1);
    check_val("b2b_first1", cap_q[1][1], 0);
    check_val("b2b_first3", cap_q[3][1], 1);
    check_val("b2b_last2", cap_q[2][0], 1);
    check_val("b2b_last5", cap_q[5][0], 1);
    check_vec("b2b_k3_init", vec_of(cap_q[3]), hand_init());

    // blklen = 5 arriving mid-frame is ignored; the frame still ends at step 2.
    cap_q.delete();
    cycle(0, 0, 1, 3, 1);
    cycle(1, 5, 1, 2, 2);
    cycle(0, 0, 1, 1, -1);
    idle(2);
    check_val("midload_count", cap_q.size(), 3);
    check_val("midload_last2", cap_q[2][0], 1);

    // blklen = 5 together with the first step applies to that same frame.
    cap_q.delete();
    cycle(1, 5, 1, 4, 4);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, i - 2, 3 - i);
    idle(2);
    check_val("coload_count", cap_q.size(), 5);
    check_val("coload_first0", cap_q[0][1], 1);
    check_val("coload_last2", cap_q[2][0], 0);
    check_val("coload_last4", cap_q[4][0], 1);

    // valid_in before any blklen: the step is dropped and the error flag sticks.
    do_reset(2);
    cap_q.delete();
    cycle(0, 0, 1, 6, 6);
    idle(2);
    check_val("noblk_err", err_blklen, 1);
    check_val("noblk_outputs", cap_q.size(), 0);
    check_val("noblk_valid_out", valid_out, 0);

    // Reset in the middle of a blklen = 8 frame, then a fresh frame.
    do_reset(2);
    check_val("rst_clears_err", err_blklen, 0);
    cycle(1, 8, 0, 0, 0);
    cycle(0, 0, 1, 9, 1);
    cycle(0, 0, 1, -4, 2);
    do_reset(1);
    check_val("midrst_valid_out", valid_out, 0);
    check_val("midrst_busy", busy, 0);
    cap_q.delete();
    cycle(1, 2, 0, 0, 0);
    cycle(0, 0, 1, 10, 0);
    cycle(0, 0, 1, 0, 0);
    idle(2);
    check_val("post_rst_count", cap_q.size(), 2);
    check_vec("post_rst_k0", vec_of(cap_q[0]), hand_init());
    check_val("post_rst_first", cap_q[0][1], 1);
    check_val("post_rst_a4", fld(cap_q[1], 4), 10);
    check_val("post_rst_last", cap_q[1][0], 1);

    idle(2);
    check_val("pending_expected", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
